// File: rtl/vote_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vote_arbiter_if                                                      |
// | Request/vote bus and response handshake between requesters and the  |
// | vote arbiter.                                                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface vote_arbiter_if;
    logic [3:0]  req;
    logic [15:0] vec;
    logic [3:0]  gnt;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic        resp_f;
    logic        resp_ready;
    logic        busy;

    modport master (
        output req, vec, resp_ready,
        input  gnt, resp_valid, resp_id, resp_f, busy
    );

    modport slave (
        input  req, vec, resp_ready,
        output gnt, resp_valid, resp_id, resp_f, busy
    );
endinterface
`default_nettype wire

// File: rtl/vote_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vote_arbiter                                                         |
// | Round-robin arbiter that grants one requester and returns a          |
// | threshold vote (popcount >= THRESH) over its latched 4-bit vector.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vote_arbiter #(
    parameter int THRESH = 3
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    vote_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] THRESH_C = 3'(THRESH);

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  id_q, id_d;
    logic [3:0]  vote_q, vote_d;
    logic [3:0]  gnt_q, gnt_d;
    logic        resp_f_q, resp_f_d;
    logic        resp_valid_q, resp_valid_d;
    logic        busy_q, busy_d;

    logic [1:0]  pick;
    logic        pick_vld;
    logic [1:0]  cand;
    logic [2:0]  ones;

    // Scan downward so the lowest offset from ptr wins.
    always_comb begin
        pick     = 2'd0;
        pick_vld = 1'b0;
        cand     = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (bus.req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    assign ones = {2'b00, vote_q[0]} + {2'b00, vote_q[1]}
                + {2'b00, vote_q[2]} + {2'b00, vote_q[3]};

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        vote_d       = vote_q;
        gnt_d        = 4'b0000;
        resp_f_d     = resp_f_q;
        resp_valid_d = resp_valid_q;
        busy_d       = busy_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    id_d    = pick;
                    vote_d  = bus.vec[{pick, 2'b00} +: 4];
                    gnt_d   = 4'b0001 << pick;
                    busy_d  = 1'b1;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                resp_f_d     = (ones >= THRESH_C);
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    ptr_d        = id_q + 2'd1;
                    state_d      = IDLE;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= 2'd0;
            id_q         <= 2'd0;
            vote_q       <= 4'b0000;
            gnt_q        <= 4'b0000;
            resp_f_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            vote_q       <= vote_d;
            gnt_q        <= gnt_d;
            resp_f_q     <= resp_f_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = id_q;
    assign bus.resp_f     = resp_f_q;
    assign bus.busy       = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_vote_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vote_arbiter                                                      |
// | Directed bench for vote_arbiter with THRESH = 3, 1 and 4.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_vote_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    vote_arbiter_if m ();
    vote_arbiter_if t1 ();
    vote_arbiter_if t4 ();

    vote_arbiter #(.THRESH(3)) dut   (.clk(clk), .rst_n(rst_n), .bus(m));
    vote_arbiter #(.THRESH(1)) dut_1 (.clk(clk), .rst_n(rst_n), .bus(t1));
    vote_arbiter #(.THRESH(4)) dut_4 (.clk(clk), .rst_n(rst_n), .bus(t4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bit v set where popcount(v) >= 3: v = 7, 11, 13, 14, 15.
    logic [15:0] f_tab;
    logic [3:0]  order [5];

    initial begin
        f_tab = 16'b1110_1000_1000_0000;
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;

        rst_n = 1'b1;
        m.req = '0;  m.vec = '0;  m.resp_ready = 1'b1;
        t1.req = '0; t1.vec = '0; t1.resp_ready = 1'b1;
        t4.req = '0; t4.vec = '0; t4.resp_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gnt", m.gnt, 4'b0);
        chk("rst_valid", m.resp_valid, 0);
        chk("rst_id", m.resp_id, 0);
        chk("rst_f", m.resp_f, 0);
        chk("rst_busy", m.busy, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single request, requester 0, vote 0111
        m.req = 4'b0001; m.vec = 16'h0007;
        tick();
        chk("r0_gnt", m.gnt, 4'b0001);
        chk("r0_busy", m.busy, 1);
        chk("r0_valid_early", m.resp_valid, 0);
        m.req = 4'b0000;
        tick();
        chk("r0_gnt_off", m.gnt, 4'b0000);
        chk("r0_valid", m.resp_valid, 1);
        chk("r0_id", m.resp_id, 0);
        chk("r0_f", m.resp_f, 1);
        tick();
        chk("r0_done_valid", m.resp_valid, 0);
        chk("r0_done_busy", m.busy, 0);

        // All 16 vote patterns on requester 1
        for (int v = 0; v < 16; v++) begin
            m.req = 4'b0010;
            m.vec = 16'(v) << 4;
            tick();
            chk("r1_gnt", m.gnt, 4'b0010);
            m.req = 4'b0000;
            tick();
            chk("r1_valid", m.resp_valid, 1);
            chk("r1_id", m.resp_id, 1);
            chk("r1_f", m.resp_f, f_tab[v]);
            tick();
        end

        // Round robin from reset with all requesters held
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        m.req = 4'b1111; m.vec = 16'h0000;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk("rr_gnt", m.gnt, order[g]);
            tick();
            chk("rr_gap1", m.gnt, 4'b0000);
            tick();
            chk("rr_gap2", m.gnt, 4'b0000);
        end

        // Backpressure: ptr=1, requester 2 with vote 1011
        m.req = 4'b0100; m.vec = 16'h0B00; m.resp_ready = 1'b0;
        tick();
        chk("bp_gnt", m.gnt, 4'b0100);
        m.req = 4'b1011; m.vec = 16'h0000;
        tick();
        chk("bp_valid0", m.resp_valid, 1);
        chk("bp_id0", m.resp_id, 2);
        chk("bp_f0", m.resp_f, 1);
        for (int k = 0; k < 4; k++) begin
            m.req = ~m.req;
            m.vec = ~m.vec;
            tick();
            chk("bp_valid", m.resp_valid, 1);
            chk("bp_id", m.resp_id, 2);
            chk("bp_f", m.resp_f, 1);
            chk("bp_gnt_off", m.gnt, 4'b0000);
        end
        m.req = 4'b0000; m.resp_ready = 1'b1;
        tick();
        chk("bp_hs_valid", m.resp_valid, 0);
        m.req = 4'b1010;
        tick();
        chk("bp_ptr_gnt", m.gnt, 4'b1000);
        m.req = 4'b0000;
        tick();
        chk("bp_ptr_id", m.resp_id, 3);
        tick();

        // Request withdrawn before it is sampled
        m.req = 4'b0100;
        #2 m.req = 4'b0000;
        tick();
        chk("drop_gnt", m.gnt, 4'b0000);
        chk("drop_busy", m.busy, 0);

        // Reset while in RESP
        m.req = 4'b0100; m.resp_ready = 1'b0;
        tick();
        chk("rr_rsp_gnt", m.gnt, 4'b0100);
        m.req = 4'b0000;
        tick();
        chk("rr_rsp_valid", m.resp_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", m.resp_valid, 0);
        chk("arst_id", m.resp_id, 0);
        chk("arst_busy", m.busy, 0);
        m.req = 4'b1000; m.resp_ready = 1'b1;
        tick();
        chk("arst_hold_valid", m.resp_valid, 0);
        rst_n = 1'b1;
        tick();
        chk("arst_gnt3", m.gnt, 4'b1000);
        m.req = 4'b0000;
        tick();
        chk("arst_id3", m.resp_id, 3);
        chk("arst_valid3", m.resp_valid, 1);
        tick();

        // Move ptr to 2, reset, then scan must start at 0
        m.req = 4'b0010;
        tick();
        chk("pre_gnt1", m.gnt, 4'b0010);
        m.req = 4'b0000;
        tick();
        tick();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        m.req = 4'b1001;
        tick();
        chk("ptr0_gnt", m.gnt, 4'b0001);
        m.req = 4'b0000;
        tick();
        tick();

        // THRESH = 1 and THRESH = 4 builds
        t1.req = 4'b0001; t1.vec = 16'h0001;
        t4.req = 4'b0001; t4.vec = 16'h0001;
        tick();
        chk("t1_gnt", t1.gnt, 4'b0001);
        chk("t4_gnt", t4.gnt, 4'b0001);
        t1.req = 4'b0000; t4.req = 4'b0000;
        tick();
        chk("t1_f_0001", t1.resp_f, 1);
        chk("t4_f_0001", t4.resp_f, 0);
        tick();
        t1.req = 4'b0001; t1.vec = 16'h000F;
        t4.req = 4'b0001; t4.vec = 16'h000F;
        tick();
        t1.req = 4'b0000; t4.req = 4'b0000;
        tick();
        chk("t1_f_1111", t1.resp_f, 1);
        chk("t4_f_1111", t4.resp_f, 1);
        chk("t4_valid", t4.resp_valid, 1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vote_arbiter.md
VOTE_ARBITER -- requirements
Module: vote_arbiter

Interface
REQ-001 Parameter: THRESH, default 3, minimum count of 1 bits in a 4-bit vote vector for resp_f=1; legal range 1..4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  per-requester request; bit i = requester i.
REQ-005 vec  input  16  vote vectors, requester i on vec[4i+3:4i], bit order x1=LSB..x4=MSB.
REQ-006 gnt  output  4  one-hot grant, registered.
REQ-007 resp_valid  output  1  result available.
REQ-008 resp_id  output  2  index of the requester whose result is presented.
REQ-009 resp_f  output  1  threshold result for the granted vector.
REQ-010 resp_ready  input  1  consumer accepts the result.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, EVAL, RESP.
REQ-013 In IDLE with req==0, the FSM SHALL remain in IDLE with gnt=0.
REQ-014 In IDLE with req!=0, the FSM SHALL select the first set bit in req, scanning ptr, ptr+1, ... mod 4; SHALL latch that index and vec slice; SHALL go to EVAL.
REQ-015 In EVAL, gnt SHALL be one-hot at the latched index for exactly that one cycle; gnt SHALL be 0 in every other state.
REQ-016 In EVAL, resp_f SHALL be registered as (popcount(latched vector) >= THRESH); with THRESH=3 this equals (x1&x2&x3)|(x1&x3&x4)|(x1&x2&x4)|(x2&x3&x4). The FSM SHALL go to RESP.
REQ-017 In RESP, resp_valid SHALL be 1, and resp_id and resp_f SHALL be held stable until the cycle where resp_valid&&resp_ready.
REQ-018 On the RESP handshake, ptr SHALL become (resp_id+1) mod 4 and the FSM SHALL return to IDLE.
REQ-019 Latency: a req sampled in IDLE at edge N SHALL give gnt after N+1 and resp_valid after N+2; with resp_ready tied high, back-to-back grants SHALL be spaced 3 cycles apart.
REQ-020 Changes on req and vec during EVAL and RESP SHALL be ignored; the latched vector alone determines resp_f.
REQ-021 A requester whose req drops before selection in IDLE SHALL NOT be granted.
REQ-022 resp_ready asserted outside RESP SHALL have no effect.
REQ-023 Requester i with req held SHALL wait at most 3 other grants before its own grant (round-robin fairness).
REQ-024 ptr wrap: after serving requester 3, scan SHALL start at requester 0.

Reset
REQ-025 When rst_n is low, outputs SHALL be gnt=0, resp_valid=0, resp_id=0, resp_f=0, busy=0, with state=IDLE and ptr=0, immediately and independent of clk.
REQ-026 Reset asserted in EVAL or RESP SHALL discard the pending transaction without producing a response.
REQ-027 After rst_n deasserts, the first scan SHALL start at requester 0.

Verification
REQ-028 Reset, then req=0001, vec[3:0]=0111, resp_ready=1 -> gnt=0001 for one cycle; resp_valid=1, resp_id=0, resp_f=1 two cycles after the request edge.
REQ-029 req=0010, vec[7:4]=0101 -> resp_id=1, resp_f=0; repeat with vec[7:4] set to 1011, 1101, 1110, 1111 -> resp_f=1 each; run all 16 vectors, resp_f=1 only for popcount>=3.
REQ-030 req=1111 held, resp_ready=1 from reset -> grant order 0,1,2,3,0, with consecutive grants 3 cycles apart.
REQ-031 resp_ready=0 for 5 cycles in RESP while req and vec toggle -> resp_valid, resp_id and resp_f stable; handshake on the 6th cycle; ptr advances.
REQ-032 rst_n pulsed low during RESP -> resp_valid=0 at once; after release with req=1000, the first grant goes to requester 3 and ptr restarts from 0.
REQ-033 THRESH=1 and THRESH=4 builds with vec=0001 -> resp_f=1 for THRESH=1 and 0 for THRESH=4; with vec=1111, resp_f=1 for both.
